sd_cmd_responder: RTL



---
 rtl/sdhci_pkg.sv | 21 ++
 rtl/sd_crc7.sv | 21 ++
 rtl/sd_cmd_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sdhci_pkg.sv
// rtl/sdhci_pkg.sv - SD CMD frame layout, responder FSM states and serial CRC7 step
package sdhci_pkg;

   localparam int FRAME_LEN   = 48;
   localparam int CRC_COVER   = 40;   // frame bits 47..8 feed the CRC
   localparam int POS_TRANS   = 46;
   localparam int POS_IDX_LSB = 40;
   localparam int POS_ARG_LSB = 8;
   localparam int POS_CRC_LSB = 1;
   localparam int POS_END     = 0;
   localparam logic [6:0] CRC7_POLY = 7'h09;

   typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_WAIT, ST_TX} state_t;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1) with clear and enable
module sd_crc7
   import sdhci_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       bit_i,
   output logic [6:0] crc_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         crc_o <= 7'h00;
      end else if (en_i) begin
         crc_o <= crc7_step(crc_o, bit_i);
      end
   end

endmodule

// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line: command receive, response transmit
// Optional SD_CMD_RSP_ERR_INJECT_EN adds CRC/end-bit corruption inputs for responses.
module sd_cmd_responder
   import sdhci_pkg::*;
#(
   parameter int NcrMin = 2,
   parameter int NcrMax = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sd_clk_en_i,
   input  logic        cmd_i,
   output logic        cmd_o,
   output logic        cmd_en_o,
   output logic        cmd_valid_o,
   output logic [5:0]  cmd_index_o,
   output logic [31:0] cmd_arg_o,
   output logic        cmd_err_o,
   input  logic        rsp_valid_i,
   output logic        rsp_ready_o,
   input  logic [5:0]  rsp_index_i,
   input  logic [31:0] rsp_arg_i,
`ifdef SD_CMD_RSP_ERR_INJECT_EN
   input  logic        inject_crc_err_i,
   input  logic        inject_end_err_i,
`endif
   output logic        rsp_timeout_o,
   output logic        busy_o
);

   localparam int GapW = $clog2(NcrMax + 1);
   localparam logic [5:0] LastBit = 6'(FRAME_LEN - 1);
   localparam logic [5:0] CrcBits = 6'(CRC_COVER);
   localparam logic [GapW-1:0] GapMin = GapW'(NcrMin);
   localparam logic [GapW-1:0] GapMax = GapW'(NcrMax);

   state_t          state;
   logic [5:0]      bit_cnt;
   logic [45:0]     rx_sr;
   logic [46:0]     rx_frame;
   logic [GapW-1:0] gap;
   logic [GapW-1:0] gap_now;
   logic [39:0]     tx_sr;
   logic [39:0]     tx_src;
   logic            have_rsp, inj_crc, inj_end, inj_crc_in, inj_end_in;
   logic            tick, handshake, frame_ok;
   logic            rx_crc_clr, rx_crc_en, tx_crc_clr, tx_crc_en;
   logic [6:0]      rx_crc, tx_crc;

   assign tick      = sd_clk_en_i;
   assign handshake = rsp_valid_i & rsp_ready_o;
   assign gap_now   = gap + GapW'(1);
   assign rx_frame  = {rx_sr, cmd_i};
   assign frame_ok  = rx_frame[POS_TRANS] & rx_frame[POS_END]
                    & (rx_frame[POS_CRC_LSB +: 7] == rx_crc);
   // a response handed over on the very tick TX starts must be shifted out directly
   assign tx_src    = handshake ? {2'b00, rsp_index_i, rsp_arg_i} : tx_sr;

`ifdef SD_CMD_RSP_ERR_INJECT_EN
   assign inj_crc_in = inject_crc_err_i;
   assign inj_end_in = inject_end_err_i;
`else
   assign inj_crc_in = 1'b0;
   assign inj_end_in = 1'b0;
`endif

   assign rx_crc_clr = (state != ST_RX);
   assign rx_crc_en  = tick && (state == ST_RX) && (bit_cnt < CrcBits);
   assign tx_crc_clr = (state != ST_TX);
   assign tx_crc_en  = tick && (state == ST_TX) && (bit_cnt < CrcBits);

   sd_crc7 u_rx_crc (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (rx_crc_clr),
      .en_i  (rx_crc_en),
      .bit_i (cmd_i),
      .crc_o (rx_crc)
   );

   sd_crc7 u_tx_crc (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (tx_crc_clr),
      .en_i  (tx_crc_en),
      .bit_i (tx_sr[CRC_COVER-1]),
      .crc_o (tx_crc)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= ST_IDLE;
         bit_cnt       <= 6'd0;
         rx_sr         <= '0;
         gap           <= '0;
         tx_sr         <= '0;
         have_rsp      <= 1'b0;
         inj_crc       <= 1'b0;
         inj_end       <= 1'b0;
         cmd_o         <= 1'b1;
         cmd_en_o      <= 1'b0;
         cmd_valid_o   <= 1'b0;
         cmd_err_o     <= 1'b0;
         cmd_index_o   <= 6'd0;
         cmd_arg_o     <= 32'd0;
         rsp_ready_o   <= 1'b0;
         rsp_timeout_o <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         cmd_valid_o   <= 1'b0;
         cmd_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;

         if (handshake) begin
            tx_sr       <= tx_src;
            have_rsp    <= 1'b1;
            rsp_ready_o <= 1'b0;
            inj_crc     <= inj_crc_in;
            inj_end     <= inj_end_in;
         end

         case (state)
            ST_IDLE: begin
               if (tick && !cmd_i) begin
                  state   <= ST_RX;
                  bit_cnt <= 6'd1;
                  busy_o  <= 1'b1;
               end
            end
            ST_RX: begin
               if (tick) begin
                  if (bit_cnt == LastBit) begin
                     if (frame_ok) begin
                        cmd_valid_o <= 1'b1;
                        cmd_index_o <= rx_frame[POS_IDX_LSB +: 6];
                        cmd_arg_o   <= rx_frame[POS_ARG_LSB +: 32];
                        state       <= ST_WAIT;
                        gap         <= '0;
                        have_rsp    <= 1'b0;
                        rsp_ready_o <= 1'b1;
                     end else begin
                        cmd_err_o <= 1'b1;
                        state     <= ST_IDLE;
                        busy_o    <= 1'b0;
                     end
                  end else begin
                     rx_sr   <= {rx_sr[44:0], cmd_i};
                     bit_cnt <= bit_cnt + 6'd1;
                  end
               end
            end
            ST_WAIT: begin
               if (tick) begin
                  if (!cmd_i) begin
                     // host started a new command: drop whatever was pending
                     state       <= ST_RX;
                     bit_cnt     <= 6'd1;
                     have_rsp    <= 1'b0;
                     rsp_ready_o <= 1'b0;
                  end else if ((have_rsp || handshake) && gap_now >= GapMin) begin
                     state       <= ST_TX;
                     cmd_en_o    <= 1'b1;
                     cmd_o       <= 1'b0;
                     bit_cnt     <= 6'd1;
                     tx_sr       <= tx_src << 1;
                     rsp_ready_o <= 1'b0;
                  end else if (gap_now == GapMax && !have_rsp && !handshake) begin
                     rsp_timeout_o <= 1'b1;
                     rsp_ready_o   <= 1'b0;
                     state         <= ST_IDLE;
                     busy_o        <= 1'b0;
                  end else begin
                     gap <= gap_now;
                  end
               end
            end
            ST_TX: begin
               if (tick) begin
                  if (bit_cnt < CrcBits) begin
                     cmd_o <= tx_sr[CRC_COVER-1];
                     tx_sr <= tx_sr << 1;
                  end else if (bit_cnt < LastBit) begin
                     cmd_o <= tx_crc[3'(6'd46 - bit_cnt)] ^ inj_crc;
                  end else if (bit_cnt == LastBit) begin
                     cmd_o <= ~inj_end;
                  end else begin
                     cmd_o    <= 1'b1;
                     cmd_en_o <= 1'b0;
                     have_rsp <= 1'b0;
                     state    <= ST_IDLE;
                     busy_o   <= 1'b0;
                  end
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
